// File: rtl/input_debounce_sync_if.sv
// Input conditioning bus between the pin/switch side and the debounce block.
//   ena        : global enable, holds all debounce state when low
//   raw_in     : unsynchronised input bits
//   clean_out  : debounced level per bit
//   rise_pulse : one-cycle pulse on a clean 0->1 transition
//   fall_pulse : one-cycle pulse on a clean 1->0 transition
//   busy       : per bit, a candidate change is being qualified
// master drives ena/raw_in; slave (the debounce block) drives the rest.
interface input_debounce_sync_if #(
   parameter int WIDTH = 2
);
   logic             ena;
   logic [WIDTH-1:0] raw_in;
   logic [WIDTH-1:0] clean_out;
   logic [WIDTH-1:0] rise_pulse;
   logic [WIDTH-1:0] fall_pulse;
   logic [WIDTH-1:0] busy;

   modport master (
      output ena, raw_in,
      input  clean_out, rise_pulse, fall_pulse, busy
   );

   modport slave (
      input  ena, raw_in,
      output clean_out, rise_pulse, fall_pulse, busy
   );
endinterface

// File: rtl/input_debounce_sync.sv
// Per-bit input conditioning: 2-flop synchroniser, counter-based debounce
// and registered single-cycle edge pulses. Bit 0 feeds adder operand a,
// bit 1 feeds adder operand b.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : input_debounce_sync_if.slave (ena, raw_in in; clean_out,
//           rise_pulse, fall_pulse, busy out)
//
// Per-bit state table:
//   state     | meaning
//   S_LO      | stable low, clean=0, cnt=0
//   S_QUAL_HI | clean=0, counting consecutive high samples
//   S_HI      | stable high, clean=1, cnt=0
//   S_QUAL_LO | clean=1, counting consecutive low samples
module input_debounce_sync #(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   input_debounce_sync_if.slave bus
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_LO      = 2'd0,
      S_QUAL_HI = 2'd1,
      S_HI      = 2'd2,
      S_QUAL_LO = 2'd3
   } state_t;

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;

   // Synchroniser is never gated so metastability protection always holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus.raw_in;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      state_t           state_q, state_nxt;
      logic [CNT_W-1:0] cnt_q, cnt_nxt;
      logic             rise_q, rise_nxt;
      logic             fall_q, fall_nxt;
      logic             clean_b, busy_b;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= S_LO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            rise_q  <= rise_nxt;
            fall_q  <= fall_nxt;
         end
      end

      // Any sample matching the current clean level restarts qualification.
      always_comb begin
         state_nxt = state_q;
         cnt_nxt   = cnt_q;
         rise_nxt  = 1'b0;
         fall_nxt  = 1'b0;
         if (bus.ena) begin
            case (state_q)
               S_LO: begin
                  if (sync2[i]) begin
                     state_nxt = S_QUAL_HI;
                     cnt_nxt   = CNT_ONE;
                  end
               end
               S_QUAL_HI: begin
                  if (!sync2[i]) begin
                     state_nxt = S_LO;
                     cnt_nxt   = '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_nxt = S_HI;
                     cnt_nxt   = '0;
                     rise_nxt  = 1'b1;
                  end else begin
                     cnt_nxt = cnt_q + CNT_ONE;
                  end
               end
               S_HI: begin
                  if (!sync2[i]) begin
                     state_nxt = S_QUAL_LO;
                     cnt_nxt   = CNT_ONE;
                  end
               end
               S_QUAL_LO: begin
                  if (sync2[i]) begin
                     state_nxt = S_HI;
                     cnt_nxt   = '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_nxt = S_LO;
                     cnt_nxt   = '0;
                     fall_nxt  = 1'b1;
                  end else begin
                     cnt_nxt = cnt_q + CNT_ONE;
                  end
               end
               default: begin
                  state_nxt = S_LO;
                  cnt_nxt   = '0;
               end
            endcase
         end
      end

      always_comb begin
         clean_b = (state_q == S_HI) || (state_q == S_QUAL_LO);
         busy_b  = (state_q == S_QUAL_HI) || (state_q == S_QUAL_LO);
      end

      assign bus.clean_out[i]  = clean_b;
      assign bus.busy[i]       = busy_b;
      // Pulses are forced low for the whole time ena is low, including a
      // pulse registered just before ena dropped.
      assign bus.rise_pulse[i] = rise_q & bus.ena;
      assign bus.fall_pulse[i] = fall_q & bus.ena;
   end
endmodule

// File: tb/tb_input_debounce_sync.sv
module tb_input_debounce_sync;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   input_debounce_sync_if #(.WIDTH(2)) bus ();

   input_debounce_sync #(
      .WIDTH           (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed {clean,rise,fall,busy}=%b expected %b", tag, obs, exp);
   endtask

   // Advance one clock edge, then sample on the falling edge.
   task automatic tick_chk(input string tag, input logic [1:0] c, input logic [1:0] r,
                           input logic [1:0] f, input logic [1:0] b);
      @(posedge clk);
      @(negedge clk);
      chk(tag, {bus.clean_out, bus.rise_pulse, bus.fall_pulse, bus.busy}, {c, r, f, b});
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      // 1. reset with inputs high, then idle
      bus.ena    = 1'b1;
      bus.raw_in = 2'b11;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset", {bus.clean_out, bus.rise_pulse, bus.fall_pulse, bus.busy}, 8'h00);
      bus.raw_in = 2'b00;
      rst_n      = 1'b1;
      for (int i = 0; i < 20; i++) tick_chk($sformatf("idle_%0d", i), 2'b00, 2'b00, 2'b00, 2'b00);

      // 2. clean rise on bit0
      bus.raw_in = 2'b01;
      tick_chk("rise0_e1", 2'b00, 2'b00, 2'b00, 2'b00);
      tick_chk("rise0_e2", 2'b00, 2'b00, 2'b00, 2'b00);
      tick_chk("rise0_e3", 2'b00, 2'b00, 2'b00, 2'b01);
      tick_chk("rise0_e4", 2'b00, 2'b00, 2'b00, 2'b01);
      tick_chk("rise0_e5", 2'b00, 2'b00, 2'b00, 2'b01);
      tick_chk("rise0_e6", 2'b01, 2'b01, 2'b00, 2'b00);
      tick_chk("rise0_e7", 2'b01, 2'b00, 2'b00, 2'b00);

      // 3a. bit1 high for 3 cycles: rejected
      bus.raw_in = 2'b11;
      tick_chk("gl3_e1", 2'b01, 2'b00, 2'b00, 2'b00);
      tick_chk("gl3_e2", 2'b01, 2'b00, 2'b00, 2'b00);
      tick_chk("gl3_e3", 2'b01, 2'b00, 2'b00, 2'b10);
      bus.raw_in = 2'b01;
      tick_chk("gl3_e4", 2'b01, 2'b00, 2'b00, 2'b10);
      tick_chk("gl3_e5", 2'b01, 2'b00, 2'b00, 2'b10);
      tick_chk("gl3_e6", 2'b01, 2'b00, 2'b00, 2'b00);
      tick_chk("gl3_e7", 2'b01, 2'b00, 2'b00, 2'b00);
      tick_chk("gl3_e8", 2'b01, 2'b00, 2'b00, 2'b00);

      // 3b. bit1 high for 4 cycles: accepted, then it falls back
      bus.raw_in = 2'b11;
      tick_chk("gl4_e1", 2'b01, 2'b00, 2'b00, 2'b00);
      tick_chk("gl4_e2", 2'b01, 2'b00, 2'b00, 2'b00);
      tick_chk("gl4_e3", 2'b01, 2'b00, 2'b00, 2'b10);
      tick_chk("gl4_e4", 2'b01, 2'b00, 2'b00, 2'b10);
      bus.raw_in = 2'b01;
      tick_chk("gl4_e5", 2'b01, 2'b00, 2'b00, 2'b10);
      tick_chk("gl4_e6", 2'b11, 2'b10, 2'b00, 2'b00);
      tick_chk("gl4_e7", 2'b11, 2'b00, 2'b00, 2'b10);
      tick_chk("gl4_e8", 2'b11, 2'b00, 2'b00, 2'b10);
      tick_chk("gl4_e9", 2'b11, 2'b00, 2'b00, 2'b10);
      tick_chk("gl4_e10", 2'b01, 2'b00, 2'b10, 2'b00);

      // 4. bring both high, then drop both together
      bus.raw_in = 2'b11;
      ticks(8);
      chk("both_hi", {bus.clean_out, bus.rise_pulse, bus.fall_pulse, bus.busy}, 8'b11_00_00_00);
      bus.raw_in = 2'b00;
      tick_chk("fall_e1", 2'b11, 2'b00, 2'b00, 2'b00);
      tick_chk("fall_e2", 2'b11, 2'b00, 2'b00, 2'b00);
      tick_chk("fall_e3", 2'b11, 2'b00, 2'b00, 2'b11);
      tick_chk("fall_e4", 2'b11, 2'b00, 2'b00, 2'b11);
      tick_chk("fall_e5", 2'b11, 2'b00, 2'b00, 2'b11);
      tick_chk("fall_e6", 2'b00, 2'b00, 2'b11, 2'b00);
      tick_chk("fall_e7", 2'b00, 2'b00, 2'b00, 2'b00);

      // 5. enable freeze after two qualifying cycles
      bus.raw_in = 2'b01;
      ticks(4);
      chk("frz_pre", {bus.clean_out, bus.rise_pulse, bus.fall_pulse, bus.busy}, 8'b00_00_00_01);
      bus.ena = 1'b0;
      for (int i = 0; i < 10; i++) tick_chk($sformatf("frz_%0d", i), 2'b00, 2'b00, 2'b00, 2'b01);
      bus.ena = 1'b1;
      tick_chk("frz_r1", 2'b00, 2'b00, 2'b00, 2'b01);
      tick_chk("frz_r2", 2'b01, 2'b01, 2'b00, 2'b00);
      tick_chk("frz_r3", 2'b01, 2'b00, 2'b00, 2'b00);

      // 6. reset in the middle of qualification
      bus.raw_in = 2'b00;
      ticks(8);
      chk("rst_pre", {bus.clean_out, bus.rise_pulse, bus.fall_pulse, bus.busy}, 8'h00);
      bus.raw_in = 2'b01;
      ticks(3);
      chk("rst_busy", {bus.clean_out, bus.rise_pulse, bus.fall_pulse, bus.busy}, 8'b00_00_00_01);
      #2 rst_n = 1'b0;
      #1 chk("rst_async", {bus.clean_out, bus.rise_pulse, bus.fall_pulse, bus.busy}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      tick_chk("rr_e1", 2'b00, 2'b00, 2'b00, 2'b00);
      tick_chk("rr_e2", 2'b00, 2'b00, 2'b00, 2'b00);
      tick_chk("rr_e3", 2'b00, 2'b00, 2'b00, 2'b01);
      tick_chk("rr_e4", 2'b00, 2'b00, 2'b00, 2'b01);
      tick_chk("rr_e5", 2'b00, 2'b00, 2'b00, 2'b01);
      tick_chk("rr_e6", 2'b01, 2'b01, 2'b00, 2'b00);
      tick_chk("rr_e7", 2'b01, 2'b00, 2'b00, 2'b00);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
